// File: rtl/accumulator_16bit_if.sv
// Sample stream handshake between the upstream datapath and the accumulator.
interface accumulator_16bit_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/accumulator_16bit.sv
// 16-bit running-sum accumulator built around one time-shared 8-bit adder:
// the low byte is added first, then the carry ripples into the high byte.

module adder_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       carry_in,
    output logic [7:0] sum,
    output logic       overflow
);
    assign {overflow, sum} = 9'(a) + 9'(b) + 9'(carry_in);
endmodule

module accumulator_16bit #(
    parameter int unsigned NUM_SAMPLES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    accumulator_16bit_if.slave   in_if,
    output logic [15:0]          acc,
    output logic                 acc_overflow,
    output logic [15:0]          sample_count,
    output logic                 done
);
    localparam int unsigned ACC_W  = 16;
    localparam int unsigned BYTE_W = 8;
    localparam logic [ACC_W-1:0] FRAME_LEN = ACC_W'(NUM_SAMPLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADD_LO = 2'd1,
        ADD_HI = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic                ovf_q, ovf_d;
    logic [ACC_W-1:0]    cnt_q, cnt_d;
    logic                done_q, done_d;
    logic                frame_end_q, frame_end_d;
    logic [BYTE_W-1:0]   op_q, op_d;
    logic                carry_q, carry_d;

    logic [BYTE_W-1:0]   add_a, add_b, add_sum;
    logic                add_cin, add_cout;
    logic [ACC_W-1:0]    cnt_inc;
    logic                in_ready_c;

    adder_8bit u_adder (
        .a        (add_a),
        .b        (add_b),
        .carry_in (add_cin),
        .sum      (add_sum),
        .overflow (add_cout)
    );

    // Next-state, adder operand steering and output updates
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        frame_end_d = frame_end_q;
        op_d        = op_q;
        carry_d     = carry_q;
        add_a       = acc_q[BYTE_W-1:0];
        add_b       = op_q;
        add_cin     = 1'b0;
        cnt_inc     = cnt_q + ACC_W'(1);
        in_ready_c  = (state_q == IDLE) && !clear && !rst;

        if (clear) begin
            state_d     = IDLE;
            acc_d       = '0;
            ovf_d       = 1'b0;
            cnt_d       = '0;
            frame_end_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_if.in_valid && in_ready_c) begin
                        op_d    = in_if.in_data;
                        state_d = ADD_LO;
                        // Previous frame's total stays visible until the next frame starts
                        if (frame_end_q) begin
                            acc_d       = '0;
                            ovf_d       = 1'b0;
                            frame_end_d = 1'b0;
                        end
                    end
                end
                ADD_LO: begin
                    add_a                = acc_q[BYTE_W-1:0];
                    add_b                = op_q;
                    add_cin              = 1'b0;
                    acc_d[BYTE_W-1:0]    = add_sum;
                    carry_d              = add_cout;
                    state_d              = ADD_HI;
                end
                ADD_HI: begin
                    add_a                = acc_q[ACC_W-1:BYTE_W];
                    add_b                = '0;
                    add_cin              = carry_q;
                    acc_d[ACC_W-1:BYTE_W] = add_sum;
                    if (add_cout) begin
                        ovf_d = 1'b1;
                    end
                    if (cnt_inc == FRAME_LEN) begin
                        cnt_d       = '0;
                        done_d      = 1'b1;
                        frame_end_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            frame_end_q <= 1'b0;
            op_q        <= '0;
            carry_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            frame_end_q <= frame_end_d;
            op_q        <= op_d;
            carry_q     <= carry_d;
        end
    end

    assign in_if.in_ready = in_ready_c;
    assign acc            = acc_q;
    assign acc_overflow   = ovf_q;
    assign sample_count   = cnt_q;
    assign done           = done_q;
endmodule

// File: tb/tb_accumulator_16bit.sv
// Directed bench for accumulator_16bit: three instances (4, 300 and 1 samples per frame)
// checked every cycle against a transaction-level running-sum model.
module tb_accumulator_16bit;
    logic clk;
    logic rst;
    logic clear;
    logic       v[3];
    logic [7:0] d[3];

    logic [15:0] acc_w[3];
    logic        ovf_w[3];
    logic [15:0] cnt_w[3];
    logic        done_w[3];
    logic        rdy_w[3];

    accumulator_16bit_if if_a ();
    accumulator_16bit_if if_b ();
    accumulator_16bit_if if_c ();

    assign if_a.in_valid = v[0];
    assign if_a.in_data  = d[0];
    assign if_b.in_valid = v[1];
    assign if_b.in_data  = d[1];
    assign if_c.in_valid = v[2];
    assign if_c.in_data  = d[2];
    assign rdy_w[0] = if_a.in_ready;
    assign rdy_w[1] = if_b.in_ready;
    assign rdy_w[2] = if_c.in_ready;

    accumulator_16bit #(.NUM_SAMPLES(4)) u_n4 (
        .clk(clk), .rst(rst), .clear(clear), .in_if(if_a),
        .acc(acc_w[0]), .acc_overflow(ovf_w[0]), .sample_count(cnt_w[0]), .done(done_w[0])
    );
    accumulator_16bit #(.NUM_SAMPLES(300)) u_n300 (
        .clk(clk), .rst(rst), .clear(clear), .in_if(if_b),
        .acc(acc_w[1]), .acc_overflow(ovf_w[1]), .sample_count(cnt_w[1]), .done(done_w[1])
    );
    accumulator_16bit #(.NUM_SAMPLES(1)) u_n1 (
        .clk(clk), .rst(rst), .clear(clear), .in_if(if_c),
        .acc(acc_w[2]), .acc_overflow(ovf_w[2]), .sample_count(cnt_w[2]), .done(done_w[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;
    int done_cnt[3] = '{0, 0, 0};

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Model: a frame's total is a plain integer sum; a sample's effect lands 2 edges after accept
    int unsigned m_n[3] = '{4, 300, 1};
    longint      m_total[3];
    int          m_cnt[3];
    bit          m_done[3];
    bit          m_fe[3];
    int          m_lat[3];
    int          m_op[3];

    function automatic logic [15:0] m_acc(input int i);
        return 16'(m_total[i] % 65536);
    endfunction
    function automatic logic m_ovf(input int i);
        return m_total[i] > 65535;
    endfunction
    function automatic logic m_ready(input int i);
        return (m_lat[i] == 0) && !clear && !rst;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst || clear) begin
                m_total[i] = 0; m_cnt[i] = 0; m_done[i] = 0; m_fe[i] = 0; m_lat[i] = 0;
            end else begin
                m_done[i] = 0;
                if (m_lat[i] == 0) begin
                    if (v[i]) begin
                        if (m_fe[i]) begin
                            m_total[i] = 0;
                            m_fe[i] = 0;
                        end
                        m_op[i]  = int'(d[i]);
                        m_lat[i] = 2;
                    end
                end else begin
                    m_lat[i]--;
                    if (m_lat[i] == 0) begin
                        m_total[i] += m_op[i];
                        m_cnt[i]++;
                        if (m_cnt[i] == int'(m_n[i])) begin
                            m_cnt[i]  = 0;
                            m_done[i] = 1;
                            m_fe[i]   = 1;
                        end
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("in_ready[%0d]", i), 32'(rdy_w[i]), 32'(m_ready(i)));
                chk($sformatf("done[%0d]", i), 32'(done_w[i]), 32'(m_done[i]));
                chk($sformatf("sample_count[%0d]", i), 32'(cnt_w[i]), 32'(16'(m_cnt[i])));
                chk($sformatf("acc_overflow[%0d]", i), 32'(ovf_w[i]), 32'(m_ovf(i)));
                if (m_lat[i] == 0)
                    chk($sformatf("acc[%0d]", i), 32'(acc_w[i]), 32'(m_acc(i)));
                if (done_w[i] === 1'b1) done_cnt[i]++;
            end
        end
    end

    // Present one sample, wait (bounded) for acceptance, return in the cycle after completion
    task automatic send(input int i, input logic [7:0] val);
        bit ok = 0;
        int waited = 0;
        @(posedge clk); #1;
        v[i] = 1'b1; d[i] = val;
        while (!ok && waited < 10) begin
            @(negedge clk);
            if (rdy_w[i] === 1'b1) ok = 1;
            else waited++;
        end
        chk($sformatf("accept_in_time[%0d]", i), 32'(ok), 32'd1);
        @(posedge clk); #1;
        v[i] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_clear();
        @(posedge clk); #1; clear = 1'b1;
        @(posedge clk); #1; clear = 1'b0;
    endtask

    int dc;
    int nacc;
    int cyc;
    int sb_sum;
    logic got;
    logic pat[9];
    logic [15:0] carry_exp[4];

    initial begin
        rst = 1'b1; clear = 1'b0;
        for (int i = 0; i < 3; i++) begin v[i] = 1'b0; d[i] = 8'h00; end
        repeat (2) @(posedge clk);
        #1 chk_en = 1;
        @(negedge clk);
        chk("reset_acc", 32'(acc_w[0]), 32'h0);
        chk("reset_ovf", 32'(ovf_w[0]), 32'h0);
        chk("reset_ready_low", 32'(rdy_w[0]), 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 32'(rdy_w[0]), 32'h1);

        // Basic frame and restart
        send(0, 8'h01); send(0, 8'h02); send(0, 8'h03);
        dc = done_cnt[0];
        send(0, 8'h04);
        chk("basic_acc", 32'(acc_w[0]), 32'h000A);
        chk("basic_model_acc", 32'(m_acc(0)), 32'h000A);
        chk("basic_done", 32'(done_w[0]), 32'h1);
        @(negedge clk);
        chk("basic_done_once", 32'(done_cnt[0] - dc), 32'd1);
        send(0, 8'h05);
        chk("restart_acc", 32'(acc_w[0]), 32'h0005);
        chk("restart_count", 32'(cnt_w[0]), 32'h1);

        // Carry into the high byte
        do_clear();
        carry_exp = '{16'h00FF, 16'h01FE, 16'h02FD, 16'h03FC};
        for (int k = 0; k < 4; k++) begin
            send(0, 8'hFF);
            chk($sformatf("carry_acc_%0d", k), 32'(acc_w[0]), 32'(carry_exp[k]));
            chk($sformatf("carry_ovf_%0d", k), 32'(ovf_w[0]), 32'h0);
        end

        // Clear during ADD_HI of the third sample, then clear with a sample presented
        do_clear();
        send(0, 8'h10); send(0, 8'h10);
        chk("clear_pre_acc", 32'(acc_w[0]), 32'h0020);
        dc = done_cnt[0];
        @(posedge clk); #1 v[0] = 1'b1; d[0] = 8'h10;
        @(posedge clk); #1 v[0] = 1'b0;
        @(posedge clk); #1 clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
        @(negedge clk);
        chk("clear_hi_acc", 32'(acc_w[0]), 32'h0);
        chk("clear_hi_count", 32'(cnt_w[0]), 32'h0);
        chk("clear_hi_no_done", 32'(done_cnt[0] - dc), 32'd0);
        @(posedge clk); #1 clear = 1'b1; v[0] = 1'b1; d[0] = 8'h33;
        @(negedge clk);
        chk("clear_blocks_ready", 32'(rdy_w[0]), 32'h0);
        @(posedge clk); #1 clear = 1'b0; v[0] = 1'b0;
        @(negedge clk);
        chk("clear_not_accepted", 32'(rdy_w[0]), 32'h1);
        chk("clear_idle_acc", 32'(acc_w[0]), 32'h0);

        // Continuous valid: one accept every three cycles, nothing lost or duplicated
        do_clear();
        nacc = 0; cyc = 0; sb_sum = 0;
        @(posedge clk); #1 v[0] = 1'b1; d[0] = 8'd1;
        while (nacc < 6 && cyc < 40) begin
            @(negedge clk);
            got = rdy_w[0];
            if (cyc < 9) pat[cyc] = got;
            cyc++;
            @(posedge clk); #1;
            if (got === 1'b1) begin
                nacc++;
                sb_sum += int'(d[0]);
                d[0] = 8'(nacc + 1);
                if (nacc == 6) v[0] = 1'b0;
            end
        end
        chk("stall_accepts", 32'(nacc), 32'd6);
        for (int j = 0; j < 9; j++)
            chk($sformatf("ready_pattern_%0d", j), 32'(pat[j]), (j % 3 == 0) ? 32'd1 : 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("stall_sb_sum", 32'(sb_sum), 32'd21);
        chk("stall_acc", 32'(acc_w[0]), 32'h000B);
        chk("stall_count", 32'(cnt_w[0]), 32'h2);

        // Overflow across a 300-sample frame
        for (int k = 1; k <= 300; k++) begin
            send(1, 8'hFF);
            if (k == 257) begin
                chk("ovf_257_acc", 32'(acc_w[1]), 32'hFFFF);
                chk("ovf_257_flag", 32'(ovf_w[1]), 32'h0);
            end
            if (k == 258) begin
                chk("ovf_258_acc", 32'(acc_w[1]), 32'h00FE);
                chk("ovf_258_flag", 32'(ovf_w[1]), 32'h1);
            end
        end
        chk("ovf_final_acc", 32'(acc_w[1]), 32'h2AD4);
        chk("ovf_final_model", 32'(m_acc(1)), 32'h2AD4);
        chk("ovf_final_flag", 32'(ovf_w[1]), 32'h1);
        chk("ovf_final_done", 32'(done_w[1]), 32'h1);

        // One sample per frame
        send(2, 8'h07);
        chk("n1_acc_a", 32'(acc_w[2]), 32'h0007);
        chk("n1_done_a", 32'(done_w[2]), 32'h1);
        send(2, 8'h09);
        chk("n1_acc_b", 32'(acc_w[2]), 32'h0009);
        send(2, 8'hFF);
        chk("n1_acc_c", 32'(acc_w[2]), 32'h00FF);
        chk("n1_count", 32'(cnt_w[2]), 32'h0);

        // Reset in the middle of a sample
        do_clear();
        send(0, 8'h20); send(0, 8'h30);
        chk("mid_pre_acc", 32'(acc_w[0]), 32'h0050);
        @(posedge clk); #1 v[0] = 1'b1; d[0] = 8'h40;
        @(posedge clk); #1 v[0] = 1'b0; rst = 1'b1;
        @(posedge clk);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_acc", 32'(acc_w[0]), 32'h0);
        chk("mid_rst_count", 32'(cnt_w[0]), 32'h0);
        chk("mid_rst_done", 32'(done_w[0]), 32'h0);
        chk("mid_rst_ovf", 32'(ovf_w[1]), 32'h0);
        chk("mid_rst_ready", 32'(rdy_w[0]), 32'h1);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
